// File: rtl/rv32_pkg.sv
// Shared RV32 encodings: ALU select codes, operand-select constants and the
// ID/EX pipeline register layout.
package rv32_pkg;

  typedef enum logic [4:0] {
    ALU_PASS   = 5'h00,
    ALU_ADD    = 5'h01,
    ALU_SUB    = 5'h02,
    ALU_SLL    = 5'h03,
    ALU_SLT    = 5'h04,
    ALU_SLTU   = 5'h05,
    ALU_XOR    = 5'h06,
    ALU_SRL    = 5'h07,
    ALU_SRA    = 5'h08,
    ALU_OR     = 5'h09,
    ALU_AND    = 5'h0A,
    ALU_MUL    = 5'h0B,
    ALU_MULH   = 5'h0C,
    ALU_MULHSU = 5'h0D,
    ALU_MULHU  = 5'h0E,
    ALU_DIV    = 5'h0F,
    ALU_DIVU   = 5'h10,
    ALU_REM    = 5'h11,
    ALU_REMU   = 5'h12
  } aluop_e;

  localparam logic OP1SEL_RS1 = 1'b0;
  localparam logic OP1SEL_PC  = 1'b1;
  localparam logic OP2SEL_RS2 = 1'b0;
  localparam logic OP2SEL_IMM = 1'b1;

  // A bubble is this struct cleared to all zeros.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [4:0]  aluop;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        op1sel;
    logic        op2sel;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
  } ex_regs_t;

endpackage

// File: rtl/forward_unit.sv
// Picks one source operand from EX/MEM, MEM/WB or the registered value.
// Index 0 is never forwarded; MEM beats WB when both match.
module forward_unit
  import rv32_pkg::*;
(
  input  logic [4:0]  rs_i,
  input  logic [31:0] rs_data_i,
  input  logic [4:0]  mem_rd_i,
  input  logic        mem_regwrite_i,
  input  logic [31:0] mem_result_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        wb_regwrite_i,
  input  logic [31:0] wb_result_i,
  output logic [31:0] fwd_o
);

  logic mem_hit_s;
  logic wb_hit_s;

  assign mem_hit_s = mem_regwrite_i && (mem_rd_i != 5'd0) && (mem_rd_i == rs_i);
  assign wb_hit_s  = wb_regwrite_i  && (wb_rd_i  != 5'd0) && (wb_rd_i  == rs_i);

  // Priority select of the forwarded operand value.
  always_comb begin
    fwd_o = rs_data_i;
    if (mem_hit_s) begin
      fwd_o = mem_result_i;
    end else if (wb_hit_s) begin
      fwd_o = wb_result_i;
    end else begin
      fwd_o = rs_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// operand forwarding into the ALU and a load-use stall counter.
module id_ex_stage
  import rv32_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ID_VALID,
  input  logic [31:0] ID_PC,
  input  logic [31:0] ID_RS1_DATA,
  input  logic [31:0] ID_RS2_DATA,
  input  logic [31:0] ID_IMM,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic [4:0]  ID_RD,
  input  logic [4:0]  ID_ALUOP,
  input  logic        ID_OP1SEL,
  input  logic        ID_OP2SEL,
  input  logic        ID_REGWRITE,
  input  logic        ID_MEMREAD,
  input  logic        ID_MEMWRITE,
  input  logic [4:0]  MEM_RD,
  input  logic        MEM_REGWRITE,
  input  logic [31:0] MEM_RESULT,
  input  logic [4:0]  WB_RD,
  input  logic        WB_REGWRITE,
  input  logic [31:0] WB_RESULT,
  input  logic        FLUSH,
  input  logic        HOLD,
  output logic        STALL,
  output logic [31:0] DATA1,
  output logic [31:0] DATA2,
  output logic [4:0]  ALUOP,
  output logic        EX_VALID,
  output logic        EX_REGWRITE,
  output logic        EX_MEMREAD,
  output logic        EX_MEMWRITE,
  output logic [31:0] EX_PC,
  output logic [31:0] EX_STORE_DATA,
  output logic [4:0]  EX_RD,
  output logic [31:0] STALL_COUNT
);

  ex_regs_t    ex_q, ex_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        r1_hazard_s, r2_hazard_s, stall_s;
  logic [31:0] fwd_rs1_s, fwd_rs2_s;

  // A store also needs rs2 even when OP2SEL picks the immediate.
  assign r1_hazard_s = (ID_RS1 == ex_q.rd) && (ID_OP1SEL == OP1SEL_RS1);
  assign r2_hazard_s = (ID_RS2 == ex_q.rd) && ((ID_OP2SEL == OP2SEL_RS2) || ID_MEMWRITE);
  assign stall_s     = ID_VALID && ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0)
                       && (r1_hazard_s || r2_hazard_s);

  // Next-state: HOLD freezes, FLUSH or STALL bubbles, otherwise accept decode.
  always_comb begin
    ex_d          = ex_q;
    stall_count_d = stall_count_q;
    if (HOLD) begin
      ex_d = ex_q;
    end else if (FLUSH || stall_s) begin
      ex_d = '0;
    end else begin
      ex_d.valid    = ID_VALID;
      ex_d.regwrite = ID_REGWRITE;
      ex_d.memread  = ID_MEMREAD;
      ex_d.memwrite = ID_MEMWRITE;
      ex_d.aluop    = ID_ALUOP;
      ex_d.rd       = ID_RD;
      ex_d.rs1      = ID_RS1;
      ex_d.rs2      = ID_RS2;
      ex_d.op1sel   = ID_OP1SEL;
      ex_d.op2sel   = ID_OP2SEL;
      ex_d.pc       = ID_PC;
      ex_d.rs1_data = ID_RS1_DATA;
      ex_d.rs2_data = ID_RS2_DATA;
      ex_d.imm      = ID_IMM;
    end
    if (stall_s && !HOLD) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Pipeline and counter state registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ex_q          <= '0;
      stall_count_q <= 32'd0;
    end else begin
      ex_q          <= ex_d;
      stall_count_q <= stall_count_d;
    end
  end

  forward_unit u_fwd_rs1 (
    .rs_i           (ex_q.rs1),
    .rs_data_i      (ex_q.rs1_data),
    .mem_rd_i       (MEM_RD),
    .mem_regwrite_i (MEM_REGWRITE),
    .mem_result_i   (MEM_RESULT),
    .wb_rd_i        (WB_RD),
    .wb_regwrite_i  (WB_REGWRITE),
    .wb_result_i    (WB_RESULT),
    .fwd_o          (fwd_rs1_s)
  );

  forward_unit u_fwd_rs2 (
    .rs_i           (ex_q.rs2),
    .rs_data_i      (ex_q.rs2_data),
    .mem_rd_i       (MEM_RD),
    .mem_regwrite_i (MEM_REGWRITE),
    .mem_result_i   (MEM_RESULT),
    .wb_rd_i        (WB_RD),
    .wb_regwrite_i  (WB_REGWRITE),
    .wb_result_i    (WB_RESULT),
    .fwd_o          (fwd_rs2_s)
  );

  // Operands are combinational from the EX registers so the ALU sees no extra cycle.
  assign STALL         = stall_s;
  assign DATA1         = (ex_q.op1sel == OP1SEL_PC)  ? ex_q.pc  : fwd_rs1_s;
  assign DATA2         = (ex_q.op2sel == OP2SEL_IMM) ? ex_q.imm : fwd_rs2_s;
  assign EX_STORE_DATA = fwd_rs2_s;
  assign ALUOP         = ex_q.aluop;
  assign EX_VALID      = ex_q.valid;
  assign EX_REGWRITE   = ex_q.regwrite;
  assign EX_MEMREAD    = ex_q.memread;
  assign EX_MEMWRITE   = ex_q.memwrite;
  assign EX_PC         = ex_q.pc;
  assign EX_RD         = ex_q.rd;
  assign STALL_COUNT   = stall_count_q;

endmodule
